// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory and buffers returned words for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;

  assign if_valid    = rst & (count_q != '0);
  assign pop         = if_valid & ~id_stall;
  assign push        = rst & inflight_q & ~redirect_valid;

  // Occupancy counts the outstanding read too, so its return always has a slot.
  assign occupancy   = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue       = rst & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));

  assign imem_en     = issue;
  assign imem_addr   = rst ? pc_q : (RESET_PC & ~32'h3);
  assign if_instr    = rst ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign if_pc_plus4 = rst ? pc4_mem_q[rd_ptr_q]   : 32'h0;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d     = redirect_target & ~32'h3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC & ~32'h3;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC & ~32'h3;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Buffer storage is not reset; outputs are masked while rst is low.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc4_mem_q[wr_ptr_q]   <= inflight_pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a queue of issued-but-undelivered fetch addresses is
// the reference for what decode must see, and in which order.
module tb_fetch_stage;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic        rst_w;
  logic        imem_en_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w = 32'h0;
  logic        if_valid_w;
  logic [31:0] if_instr_w;
  logic [31:0] if_pc_plus4_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } fetch_t;

  fetch_t      q[$];
  logic [31:0] next_addr = RPC;
  int          cyc = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  fetch_stage #(.RESET_PC(RPC_W), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst_w), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .id_stall(1'b0), .if_valid(if_valid_w),
    .if_instr(if_instr_w), .if_pc_plus4(if_pc_plus4_w),
    .redirect_valid(1'b0), .redirect_target(32'h0)
  );

  // Instruction memory: the word at byte address A holds A>>2.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= imem_addr >> 2;
    if (imem_en_w) imem_rdata_w <= imem_addr_w >> 2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the main DUT: drive, check at negedge, advance model at posedge.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] tgt);
    logic exp_valid;
    logic exp_pop;
    logic exp_en;
    int   pending;
    rst = r; id_stall = s; redirect_valid = rv; redirect_target = tgt;
    @(negedge clk);
    exp_valid = r && (q.size() > 0) && (cyc - q[0].cyc >= 2);
    exp_pop   = exp_valid && !s;
    pending   = q.size() - (exp_pop ? 1 : 0);
    exp_en    = r && !rv && (pending < DEPTH);
    chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
    chk("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
    if (exp_en) chk("imem_addr", imem_addr, next_addr);
    if (!r) begin
      chk("rst_imem_addr", imem_addr, RPC);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    end
    if (exp_valid) begin
      chk("if_instr", if_instr, q[0].addr >> 2);
      chk("if_pc_plus4", if_pc_plus4, q[0].addr + 32'd4);
    end
    @(posedge clk);
    if (!r) begin
      q.delete();
      next_addr = RPC;
    end else if (rv) begin
      q.delete();
      next_addr = tgt & ~32'h3;
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_en) begin
        q.push_back('{addr: next_addr, cyc: cyc});
        next_addr = next_addr + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    rst_w = 1'b0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Free-running stream from reset
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    // Five-cycle stall mid-stream, then release
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    // Redirect with one read in flight and one buffered entry
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    // Fill the buffer under stall, then redirect to a misaligned target
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    // One-cycle reset with a read in flight
    step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 14) == 0),
           $urandom);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap on the second instance
    @(negedge clk);
    chk("wrap_rst_addr", imem_addr_w, RPC_W);
    chk("wrap_rst_valid", {31'b0, if_valid_w}, 32'h0);
    @(posedge clk); #1;
    rst_w = 1'b1;
    @(negedge clk);
    chk("wrap_en0", {31'b0, imem_en_w}, 32'h1);
    chk("wrap_addr0", imem_addr_w, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", imem_addr_w, 32'h0);
    chk("wrap_valid1", {31'b0, if_valid_w}, 32'h0);
    @(negedge clk);
    chk("wrap_valid2", {31'b0, if_valid_w}, 32'h1);
    chk("wrap_pc4_first", if_pc_plus4_w, 32'h0);
    chk("wrap_instr_first", if_instr_w, 32'h3FFF_FFFF);
    @(negedge clk);
    chk("wrap_pc4_second", if_pc_plus4_w, 32'h4);
    chk("wrap_instr_second", if_instr_w, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
